// File: rtl/axil_cmd_master.sv
// axil_cmd_master: turns a valid/ready command stream (one word per command)
// into single AXI4-Lite read or write transactions, one response per command.
// Only one transaction is in flight at a time.
//
// Optional feature: define AXIL_MST_TIMEOUT_EN to enable a watchdog that
// abandons a stuck transaction after TIMEOUT_CYCLES cycles and returns a
// timeout response. Without it the FSM waits on the slave indefinitely.
//
// state   | meaning
// IDLE    | ready for a command
// WR_AW_W | write address and write data offered, each dropped on its handshake
// WR_B    | waiting for the write response
// RD_AR   | read address offered
// RD_R    | waiting for read data
// RESP    | response held until the consumer takes it
module axil_cmd_master #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES     = 256
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [31:0]                   cmd_wdata,
  input  logic [3:0]                    cmd_wstrb,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [31:0]                   rsp_rdata,
  output logic [1:0]                    rsp_resp,
  output logic                          rsp_timeout,
  output logic                          busy,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR,
  output logic [2:0]                    M_AXI_AWPROT,
  output logic                          M_AXI_AWVALID,
  input  logic                          M_AXI_AWREADY,
  output logic [31:0]                   M_AXI_WDATA,
  output logic [3:0]                    M_AXI_WSTRB,
  output logic                          M_AXI_WVALID,
  input  logic                          M_AXI_WREADY,
  input  logic [1:0]                    M_AXI_BRESP,
  input  logic                          M_AXI_BVALID,
  output logic                          M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic [2:0]                    M_AXI_ARPROT,
  output logic                          M_AXI_ARVALID,
  input  logic                          M_AXI_ARREADY,
  input  logic [31:0]                   M_AXI_RDATA,
  input  logic [1:0]                    M_AXI_RRESP,
  input  logic                          M_AXI_RVALID,
  output logic                          M_AXI_RREADY
);

  typedef enum logic [2:0] {IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RESP} state_t;

  // Elaboration guards on unsupported parameter values.
  if (C_M_AXI_DATA_WIDTH != 32) begin : g_dw_check
    $error("axil_cmd_master supports only a 32-bit data bus");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_tmo_check
    $error("axil_cmd_master TIMEOUT_CYCLES must be at least 2");
  end

  state_t                        state;
  logic [C_M_AXI_ADDR_WIDTH-1:0] addr_q;
  logic                          unused_addr_lsb;

  // Reads and writes never overlap, so one word-aligned address register
  // serves both channels.
  assign M_AXI_AWADDR    = addr_q;
  assign M_AXI_ARADDR    = addr_q;
  assign M_AXI_AWPROT    = 3'b000;
  assign M_AXI_ARPROT    = 3'b000;
  assign busy            = (state != IDLE);
  assign unused_addr_lsb = ^cmd_addr[1:0];

`ifdef AXIL_MST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;
  logic          waiting;
  logic          tmo_hit;

  assign waiting = (state == WR_AW_W) || (state == WR_B) ||
                   (state == RD_AR) || (state == RD_R);
  assign tmo_hit = waiting && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign rsp_timeout = 1'b0;
`endif

  // Transaction FSM with all handshake and response outputs registered.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state         <= IDLE;
      cmd_ready     <= 1'b0;
      addr_q        <= '0;
      M_AXI_WDATA   <= '0;
      M_AXI_WSTRB   <= '0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_resp      <= '0;
`ifdef AXIL_MST_TIMEOUT_EN
      rsp_timeout   <= 1'b0;
      tmo_cnt       <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready   <= 1'b0;
            addr_q      <= {cmd_addr[C_M_AXI_ADDR_WIDTH-1:2], 2'b00};
            M_AXI_WDATA <= cmd_wdata;
            M_AXI_WSTRB <= cmd_wstrb;
            rsp_rdata   <= '0;
            rsp_resp    <= '0;
`ifdef AXIL_MST_TIMEOUT_EN
            rsp_timeout <= 1'b0;
`endif
            if (cmd_write) begin
              M_AXI_AWVALID <= 1'b1;
              M_AXI_WVALID  <= 1'b1;
              state         <= WR_AW_W;
            end else begin
              M_AXI_ARVALID <= 1'b1;
              state         <= RD_AR;
            end
          end
        end
        WR_AW_W: begin
          if (M_AXI_AWREADY) M_AXI_AWVALID <= 1'b0;
          if (M_AXI_WREADY)  M_AXI_WVALID  <= 1'b0;
          // A channel is done once its valid has already dropped or it
          // handshakes this cycle.
          if ((!M_AXI_AWVALID || M_AXI_AWREADY) && (!M_AXI_WVALID || M_AXI_WREADY)) begin
            M_AXI_BREADY <= 1'b1;
            state        <= WR_B;
          end
        end
        WR_B: begin
          if (M_AXI_BVALID) begin
            M_AXI_BREADY <= 1'b0;
            rsp_resp     <= M_AXI_BRESP;
            rsp_valid    <= 1'b1;
            state        <= RESP;
          end
        end
        RD_AR: begin
          if (M_AXI_ARREADY) begin
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b1;
            state         <= RD_R;
          end
        end
        RD_R: begin
          if (M_AXI_RVALID) begin
            M_AXI_RREADY <= 1'b0;
            rsp_rdata    <= M_AXI_RDATA;
            rsp_resp     <= M_AXI_RRESP;
            rsp_valid    <= 1'b1;
            state        <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
`ifdef AXIL_MST_TIMEOUT_EN
      // Watchdog overrides whatever the wait state decided this cycle.
      if (tmo_hit) begin
        M_AXI_AWVALID <= 1'b0;
        M_AXI_WVALID  <= 1'b0;
        M_AXI_BREADY  <= 1'b0;
        M_AXI_ARVALID <= 1'b0;
        M_AXI_RREADY  <= 1'b0;
        rsp_valid     <= 1'b1;
        rsp_timeout   <= 1'b1;
        rsp_resp      <= 2'b10;
        rsp_rdata     <= 32'hDEADBEEF;
        state         <= RESP;
      end
      if (waiting && !tmo_hit) tmo_cnt <= tmo_cnt + 1'b1;
      else                     tmo_cnt <= '0;
`endif
    end
  end

endmodule

// File: tb/tb_axil_cmd_master.sv
// Bench for axil_cmd_master: a small AXI4-Lite slave with four word
// registers, directed commands, and a scoreboard of expected responses.
module tb_axil_cmd_master;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        rsp_timeout, busy;
  logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR, M_AXI_RDATA;
  logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
  logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
  logic [3:0]  M_AXI_WSTRB;
  logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;
  logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
  logic        M_AXI_RVALID, M_AXI_RREADY;

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [34:0] sb [$];   // {rdata, resp, timeout}

  always #5 ACLK = ~ACLK;

  axil_cmd_master #(.C_M_AXI_ADDR_WIDTH(32), .C_M_AXI_DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout), .busy(busy),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
    .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
  );

  // ---------------- slave model ----------------
  int          aw_hold  = 1;     // cycles AWVALID stays high before AWREADY
  logic        b_block  = 1'b0;  // withhold BVALID
  logic        ar_block = 1'b0;  // withhold ARREADY
  logic [31:0] mem [4];
  int          aw_cnt;
  logic        aw_got, w_got;
  logic [31:0] aw_addr_q, w_data_q;
  logic [3:0]  w_strb_q;
  logic        aw_hs, w_hs, aw_ok, w_ok;
  logic [31:0] cur_awaddr, cur_wdata;
  logic [3:0]  cur_wstrb;

  assign M_AXI_AWREADY = M_AXI_AWVALID && !aw_got && (aw_cnt == aw_hold - 1);
  assign M_AXI_WREADY  = M_AXI_WVALID && !w_got;
  assign M_AXI_ARREADY = M_AXI_ARVALID && !ar_block;
  assign aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
  assign w_hs  = M_AXI_WVALID && M_AXI_WREADY;
  assign aw_ok = aw_got || aw_hs;
  assign w_ok  = w_got || w_hs;
  assign cur_awaddr = aw_got ? aw_addr_q : M_AXI_AWADDR;
  assign cur_wdata  = w_got ? w_data_q : M_AXI_WDATA;
  assign cur_wstrb  = w_got ? w_strb_q : M_AXI_WSTRB;

  always @(posedge ACLK) begin
    if (ARESET) begin
      aw_cnt <= 0; aw_got <= 1'b0; w_got <= 1'b0;
      M_AXI_BVALID <= 1'b0; M_AXI_BRESP <= 2'b00;
      M_AXI_RVALID <= 1'b0; M_AXI_RRESP <= 2'b00; M_AXI_RDATA <= '0;
      for (int i = 0; i < 4; i++) mem[i] <= '0;
    end else begin
      if (aw_hs) begin aw_got <= 1'b1; aw_addr_q <= M_AXI_AWADDR; aw_cnt <= 0; end
      else if (M_AXI_AWVALID && !aw_got) aw_cnt <= aw_cnt + 1;
      if (w_hs) begin w_got <= 1'b1; w_data_q <= M_AXI_WDATA; w_strb_q <= M_AXI_WSTRB; end
      if (!M_AXI_BVALID && !b_block && aw_ok && w_ok) begin
        M_AXI_BVALID <= 1'b1;
        aw_got <= 1'b0; w_got <= 1'b0;
        if (cur_awaddr >= 32'h10) M_AXI_BRESP <= 2'b10;
        else begin
          M_AXI_BRESP <= 2'b00;
          for (int b = 0; b < 4; b++)
            if (cur_wstrb[b]) mem[cur_awaddr[3:2]][8*b +: 8] <= cur_wdata[8*b +: 8];
        end
      end
      if (M_AXI_BVALID && M_AXI_BREADY) M_AXI_BVALID <= 1'b0;
      if (M_AXI_ARVALID && M_AXI_ARREADY) begin
        M_AXI_RVALID <= 1'b1;
        M_AXI_RDATA  <= (M_AXI_ARADDR >= 32'h10) ? 32'h0 : mem[M_AXI_ARADDR[3:2]];
        M_AXI_RRESP  <= (M_AXI_ARADDR >= 32'h10) ? 2'b10 : 2'b00;
      end
      if (M_AXI_RVALID && M_AXI_RREADY) M_AXI_RVALID <= 1'b0;
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctrl"}, {cmd_ready, rsp_valid, rsp_timeout, busy, M_AXI_AWVALID, M_AXI_WVALID,
                         M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY, M_AXI_AWPROT, M_AXI_ARPROT}, 64'h0);
    chk({tag, "_rsp"},  {rsp_rdata, rsp_resp}, 64'h0);
    chk({tag, "_addr"}, {M_AXI_AWADDR, M_AXI_ARADDR}, 64'h0);
    chk({tag, "_wdat"}, {M_AXI_WDATA, M_AXI_WSTRB}, 64'h0);
  endtask

  // Monitor: every response handshake pops the oldest expectation.
  initial begin
    logic [34:0] e;
    forever begin
      @(negedge ACLK); #1;
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          vec_cnt++; err_cnt++;
          $display("FAIL sb_underflow: got response %0h with no expectation queued", rsp_rdata);
        end else begin
          e = sb.pop_front();
          chk("rsp_rdata", rsp_rdata, e[34:3]);
          chk("rsp_resp", rsp_resp, e[2:1]);
          chk("rsp_timeout", rsp_timeout, e[0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  int          lat, n_awv, n_wv, n_b;
  logic [31:0] araddr_seen;

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] strb);
    int guard = 0;
    @(negedge ACLK);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
    while (!cmd_ready && guard < 50) begin @(negedge ACLK); guard++; end
    if (!cmd_ready) chk("cmd_accept_wait", cmd_ready, 1);
    @(posedge ACLK); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic do_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input logic [31:0] exp_rdata,
                        input logic [1:0] exp_resp, input int bp_cycles);
    logic [34:0] snap;
    rsp_ready = (bp_cycles == 0);
    issue(wr, addr, data, strb);
    sb.push_back({exp_rdata, exp_resp, 1'b0});
    lat = 0; n_awv = 0; n_wv = 0; n_b = 0; araddr_seen = 32'hFFFF_FFFF;
    do begin
      @(negedge ACLK); lat++;
      if (lat == 1) chk("busy", busy, 1);
      if (M_AXI_AWVALID) n_awv++;
      if (M_AXI_WVALID) n_wv++;
      if (M_AXI_BVALID && M_AXI_BREADY) n_b++;
      if (M_AXI_ARVALID) araddr_seen = M_AXI_ARADDR;
    end while (!rsp_valid && lat < 200);
    if (!rsp_valid) chk("rsp_wait", rsp_valid, 1);
    if (bp_cycles > 0) begin
      snap = {rsp_rdata, rsp_resp, rsp_timeout};
      repeat (bp_cycles) begin
        @(negedge ACLK);
        chk("bp_stable", {rsp_valid, rsp_rdata, rsp_resp, rsp_timeout}, {1'b1, snap});
        chk("bp_cmd_ready", cmd_ready, 0);
      end
      rsp_ready = 1'b1;
    end
    @(posedge ACLK); #1;
  endtask

  initial begin
    ARESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b0;
    repeat (3) @(negedge ACLK);
    chk_all_zero("reset");
    ARESET = 1'b0;
    @(negedge ACLK);
    chk("cmd_ready_after_reset", cmd_ready, 1);

    // Writes to the four registers, then read them back.
    for (int i = 0; i < 4; i++) begin
      do_cmd(1'b1, 32'(4*i), 32'(i+1), 4'hF, 32'h0, 2'b00, 0);
      chk("wr_latency", lat, 3);
    end
    for (int i = 0; i < 4; i++) begin
      do_cmd(1'b0, 32'(4*i), 32'h0, 4'h0, 32'(i+1), 2'b00, 0);
      chk("rd_latency", lat, 3);
    end

    // Partial strobe: only byte 1 of register 3 changes.
    do_cmd(1'b1, 32'hC, 32'hFFFF_FFFF, 4'b0010, 32'h0, 2'b00, 0);
    do_cmd(1'b0, 32'hC, 32'h0, 4'h0, 32'h0000_FF04, 2'b00, 0);

    // AW held 5 cycles, W accepted immediately.
    aw_hold = 5;
    do_cmd(1'b1, 32'h0, 32'hA5A5_A5A5, 4'hF, 32'h0, 2'b00, 0);
    aw_hold = 1;
    chk("skew_awvalid_cycles", n_awv, 5);
    chk("skew_wvalid_cycles", n_wv, 1);
    chk("skew_b_count", n_b, 1);

    // Slave error responses pass through.
    do_cmd(1'b1, 32'h20, 32'h1234_5678, 4'hF, 32'h0, 2'b10, 0);
    do_cmd(1'b0, 32'h24, 32'h0, 4'h0, 32'h0, 2'b10, 0);

    // Misaligned read under response backpressure.
    do_cmd(1'b0, 32'h7, 32'h0, 4'h0, 32'h2, 2'b00, 10);
    chk("araddr_aligned", araddr_seen, 32'h4);
    do_cmd(1'b0, 32'h0, 32'h0, 4'h0, 32'hA5A5_A5A5, 2'b00, 0);

    // Reset while waiting for B: everything drops, response discarded.
    b_block = 1'b1;
    issue(1'b1, 32'h4, 32'h99, 4'hF);
    begin
      int g = 0;
      while (!M_AXI_BREADY && g < 20) begin @(negedge ACLK); g++; end
    end
    chk("in_wr_b", {busy, M_AXI_BREADY}, 2'b11);
    ARESET = 1'b1;
    @(negedge ACLK);
    chk_all_zero("midop_reset");
    ARESET = 1'b0; b_block = 1'b0;
    @(negedge ACLK);
    chk("cmd_ready_after_midop", cmd_ready, 1);

    // Slave that never accepts AR.
    ar_block = 1'b1;
    rsp_ready = 1'b1;
`ifdef AXIL_MST_TIMEOUT_EN
    issue(1'b0, 32'h0, 32'h0, 4'h0);
    sb.push_back({32'hDEADBEEF, 2'b10, 1'b1});
    begin
      int g = 0;
      while (!rsp_valid && g < 100) begin @(negedge ACLK); g++; end
    end
    chk("tmo_rsp_valid", rsp_valid, 1);
    chk("tmo_arvalid_low", M_AXI_ARVALID, 0);
    @(posedge ACLK); #1;
`else
    issue(1'b0, 32'h0, 32'h0, 4'h0);
    repeat (1000) @(negedge ACLK);
    chk("no_tmo_waiting", {busy, M_AXI_ARVALID, rsp_valid, rsp_timeout}, 4'b1100);
    ARESET = 1'b1;
    @(negedge ACLK);
    ARESET = 1'b0;
`endif
    ar_block = 1'b0;

    repeat (4) @(negedge ACLK);
    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/axil_cmd_master.md
# axil_cmd_master

Hardware AXI4-Lite master that turns a simple valid/ready command stream (write or read, one word per command) into single AXI4-Lite transactions and returns one response per command. Sits directly upstream of the `my_lite_gpio_ip` S00_AXI slave port and replaces the VIP master in synthesized designs, so on-chip logic can program and read back the GPIO register bank.

## Interface
Clocking: one clock; reset is synchronous and active-high.

**Parameters**
- `C_M_AXI_ADDR_WIDTH`, default 32: AXI address width.
- `C_M_AXI_DATA_WIDTH`, default 32: data width. Only 32 is supported.
- `TIMEOUT_CYCLES`, default 256: watchdog limit. Used only when `AXIL_MST_TIMEOUT_EN` is defined.

**Ports** (clock and reset first)
- `ACLK` in 1: clock; all logic on the rising edge.
- `ARESET` in 1: synchronous reset, active-high.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: command accepted when `cmd_valid & cmd_ready`.
- `cmd_write` in 1: 1 = write, 0 = read.
- `cmd_addr` in ADDR_WIDTH: byte address. Bits [1:0] are ignored.
- `cmd_wdata` in 32: write data.
- `cmd_wstrb` in 4: write byte strobes.
- `rsp_valid` out 1: response available.
- `rsp_ready` in 1: response consumed when `rsp_valid & rsp_ready`.
- `rsp_rdata` out 32: read data; 0 for writes.
- `rsp_resp` out 2: BRESP or RRESP.
- `rsp_timeout` out 1: watchdog expired for this command.
- `busy` out 1: high whenever the FSM is not in IDLE.
- `M_AXI_AWADDR` out ADDR_WIDTH, `M_AXI_AWPROT` out 3, `M_AXI_AWVALID` out 1, `M_AXI_AWREADY` in 1.
- `M_AXI_WDATA` out 32, `M_AXI_WSTRB` out 4, `M_AXI_WVALID` out 1, `M_AXI_WREADY` in 1.
- `M_AXI_BRESP` in 2, `M_AXI_BVALID` in 1, `M_AXI_BREADY` out 1.
- `M_AXI_ARADDR` out ADDR_WIDTH, `M_AXI_ARPROT` out 3, `M_AXI_ARVALID` out 1, `M_AXI_ARREADY` in 1.
- `M_AXI_RDATA` in 32, `M_AXI_RRESP` in 2, `M_AXI_RVALID` in 1, `M_AXI_RREADY` out 1.

## Operation
- **FSM states:** IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RESP.
- **IDLE:** `cmd_ready`=1. On accept, register address (bits [1:0] forced to 00), data and strobes. Go to WR_AW_W if `cmd_write`, otherwise RD_AR.
- **WR_AW_W:**
  - AWVALID and WVALID are both high on entry.
  - Each valid drops independently after its own handshake; AW and W may complete in either order or in the same cycle.
  - Go to WR_B once both handshakes are done.
- **WR_B:** BREADY=1. On BVALID, capture BRESP and go to RESP.
- **RD_AR:** ARVALID=1 until ARREADY, then go to RD_R.
- **RD_R:** RREADY=1. On RVALID, capture RDATA and RRESP, then go to RESP.
- **RESP:** `rsp_valid`=1, held with stable `rsp_*` until `rsp_ready`, then go to IDLE.
- AWPROT and ARPROT are constant 3'b000.
- AWADDR, WDATA, WSTRB and ARADDR stay stable while their valid is high.
- Only one transaction is outstanding at a time; reads and writes are never overlapped.
- Response fields are cleared (rdata=0, resp=00, timeout=0) on every command accept.

## Timing
- **Reset values:** all outputs 0, FSM in IDLE. `cmd_ready` rises the first cycle after ARESET is deasserted.
- **Reset mid-operation:** every VALID/READY drops at the next edge and the FSM returns to IDLE; the pending response is discarded.
- **Valid outputs are registered:**
  - accept at edge N → AW/W or AR valid high after edge N.
  - Handshake at edge N+1 → BREADY/RREADY high after N+1.
  - B/R handshake at edge N+2 → `rsp_valid` after N+2.
  - Minimum command-to-response latency is 3 cycles. Back-to-back command issue interval is at least 4 cycles (RESP must exit before the next accept).
- `cmd_ready` is 0 in every state except IDLE; no command is accepted in the cycle RESP exits.
- A BVALID or RVALID already high on state entry is accepted in the first cycle.

## Configuration
- `AXIL_MST_TIMEOUT_EN` **defined:**
  - A cycle counter starts on leaving IDLE and resets on entering RESP.
  - When it reaches `TIMEOUT_CYCLES` while in WR_AW_W, WR_B, RD_AR or RD_R, all AXI valids and readies drop and the FSM goes to RESP with `rsp_timeout`=1, `rsp_resp`=2'b10 and `rsp_rdata`=32'hDEADBEEF.
  - This is a recovery path only; the slave must be reset afterwards.
- `AXIL_MST_TIMEOUT_EN` **undefined:** no counter; the FSM waits indefinitely and `rsp_timeout` is tied to 0.

## Test plan
- **Writes to GPIO regs 0x0/0x4/0x8/0xC:** write 0x1, 0x2, 0x3, 0x4 with wstrb=0xF, slave always ready → each `rsp_resp`=00, `rsp_valid` exactly 3 cycles after accept. Read back the four addresses → `rsp_rdata`=0x1..0x4.
- **AW/W skew:** AWREADY delayed 5 cycles, WREADY immediate. WVALID drops after 1 cycle, AWVALID is held 5 cycles, exactly one B is consumed, response resp=00.
- **Backpressure and misaligned address:**
  - `rsp_ready` held low for 10 cycles → `rsp_*` stable, `cmd_ready`=0 throughout.
  - `cmd_addr`=0x7 → ARADDR=0x4.
- **Reset mid-op:** assert ARESET while in WR_B → all outputs 0 next cycle, `cmd_ready`=1 the cycle after release.
- **Timeout (macro defined, `TIMEOUT_CYCLES`=16):** ARREADY never asserted → `rsp_timeout`=1, resp=10, rdata=0xDEADBEEF, ARVALID low. Macro undefined → still waiting after 1000 cycles.
